// File: rtl/nv_nvdla_pdp_rdma_pkg.sv
// Shared PDP RDMA definitions: atom geometry, scheduler FSM encoding, and mask helpers.
// Pure declarations; there are no clocked elements and no flow control.
package nv_nvdla_pdp_rdma_pkg;

  localparam int ATOM_BYTES = 32;
  localparam int ATOM_SHIFT = $clog2(ATOM_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic logic [1:0] popcount2(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_rdma_credit_cnt.sv
// Atom credit counter: take on a request handshake, return on latency-FIFO pops, with a one-cycle update.
// It never backpressures; an over-return saturates at CREDITS and pulses ovf_vld.
module nv_nvdla_pdp_rdma_credit_cnt #(
  parameter int CREDITS = 64,
  parameter int CW      = $clog2(CREDITS + 1),
  parameter int TW      = 4
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          take_vld,
  input  logic [TW-1:0] take_dat,
  input  logic [1:0]    ret_dat,
  output logic [CW-1:0] credits,
  output logic          ovf_vld
);

  // Extra headroom so the sum can exceed CREDITS without wrapping before the compare.
  localparam int XW = ((CW > TW) ? CW : TW) + 2;

  logic [XW-1:0] sum;

  assign sum     = XW'(credits) - (take_vld ? XW'(take_dat) : '0) + XW'(ret_dat);
  assign ovf_vld = (sum > XW'(CREDITS));

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credits <= CW'(CREDITS);
    end else if (ovf_vld) begin
      credits <= CW'(CREDITS);
    end else begin
      credits <= sum[CW-1:0];
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_rdma_rd_sched.sv
// PDP RDMA read scheduler: splits one command into bursts of up to BURST_MAX atoms and tracks returning atoms.
// A request is offered only when credits cover the whole burst, and it is held until it is accepted.
module nv_nvdla_pdp_rdma_rd_sched
  import nv_nvdla_pdp_rdma_pkg::*;
#(
  parameter int AW        = 64,
  parameter int LW        = 13,
  parameter int BURST_MAX = 4,
  parameter int CREDITS   = 64,
  parameter int CW        = $clog2(CREDITS + 1)
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic          dma_rd_req_valid,
  input  logic          dma_rd_req_ready,
  output logic [AW-1:0] dma_rd_req_addr,
  output logic [2:0]    dma_rd_req_size,
  input  logic          rsp_valid,
  input  logic          rsp_ready,
  input  logic [1:0]    rsp_mask,
  input  logic [1:0]    fifo_pop_atoms,
  output logic [CW-1:0] credits_avail,
  output logic          done,
  output logic          err
);

  localparam int RW = LW + 1;
  localparam int BW = 4;

  sched_state_e  state;
  sched_state_e  state_nxt;
  logic [AW-1:0] cur_addr;
  logic [RW-1:0] remain_req;
  logic [RW-1:0] remain_req_nxt;
  logic [RW-1:0] remain_rsp;
  logic [RW-1:0] remain_rsp_nxt;
  logic [BW-1:0] burst;
  logic [1:0]    rsp_cnt;
  logic          cmd_hs;
  logic          req_hs;
  logic          rsp_hs;
  logic          rsp_live;
  logic          rsp_err;
  logic          credit_ovf;

  assign cmd_ready = (state == IDLE);
  assign cmd_hs    = cmd_valid & cmd_ready;

  assign burst = (remain_req < RW'(BURST_MAX)) ? remain_req[BW-1:0] : BW'(BURST_MAX);

  // Valid depends only on registered state, so a stalled request cannot change under the consumer.
  assign dma_rd_req_valid = (state == ISSUE) && (32'(credits_avail) >= 32'(burst));
  assign dma_rd_req_addr  = cur_addr;
  assign dma_rd_req_size  = 3'(burst - BW'(1));
  assign req_hs           = dma_rd_req_valid & dma_rd_req_ready;

  assign rsp_hs   = rsp_valid & rsp_ready;
  assign rsp_cnt  = popcount2(rsp_mask);
  assign rsp_live = (state == ISSUE) || (state == WAIT);
  assign rsp_err  = rsp_hs && (!rsp_live || (rsp_mask == 2'b00) || (RW'(rsp_cnt) > remain_rsp));

  assign done = (state == DONE);

  always_comb begin
    remain_req_nxt = remain_req;
    remain_rsp_nxt = remain_rsp;
    if (req_hs) begin
      remain_req_nxt = remain_req - RW'(burst);
    end
    if (rsp_hs && rsp_live) begin
      remain_rsp_nxt = (RW'(rsp_cnt) > remain_rsp) ? '0 : (remain_rsp - RW'(rsp_cnt));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_hs) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (remain_req_nxt == '0) begin
          state_nxt = (remain_rsp_nxt == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (remain_rsp_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remain_req <= '0;
      remain_rsp <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err | rsp_err | credit_ovf;
      if (cmd_hs) begin
        cur_addr   <= {cmd_addr[AW-1:ATOM_SHIFT], ATOM_SHIFT'(0)};
        remain_req <= RW'(cmd_len) + RW'(1);
        remain_rsp <= RW'(cmd_len) + RW'(1);
      end else begin
        if (req_hs) begin
          cur_addr <= cur_addr + (AW'(burst) << ATOM_SHIFT);
        end
        remain_req <= remain_req_nxt;
        remain_rsp <= remain_rsp_nxt;
      end
    end
  end

  nv_nvdla_pdp_rdma_credit_cnt #(
    .CREDITS (CREDITS),
    .CW      (CW),
    .TW      (BW)
  ) u_credit_cnt (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .take_vld       (req_hs),
    .take_dat       (burst),
    .ret_dat        (fifo_pop_atoms),
    .credits        (credits_avail),
    .ovf_vld        (credit_ovf)
  );

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_rd_sched.sv
// Directed bench for the PDP RDMA read scheduler: a 64-credit instance and a 4-credit instance.
module tb_nv_nvdla_pdp_rdma_rd_sched;

  logic        clk;
  logic        rst;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_mask;
  logic [1:0]  pop;
  logic [6:0]  credits;
  logic        done;
  logic        err;

  logic        b_cmd_valid;
  logic        b_cmd_ready;
  logic [63:0] b_cmd_addr;
  logic [12:0] b_cmd_len;
  logic        b_req_valid;
  logic        b_req_ready;
  logic [63:0] b_req_addr;
  logic [2:0]  b_req_size;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [1:0]  b_rsp_mask;
  logic [1:0]  b_pop;
  logic [2:0]  b_credits;
  logic        b_done;
  logic        b_err;

  int checks = 0;
  int errors = 0;

  nv_nvdla_pdp_rdma_rd_sched u_dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_len          (cmd_len),
    .dma_rd_req_valid (req_valid),
    .dma_rd_req_ready (req_ready),
    .dma_rd_req_addr  (req_addr),
    .dma_rd_req_size  (req_size),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_mask         (rsp_mask),
    .fifo_pop_atoms   (pop),
    .credits_avail    (credits),
    .done             (done),
    .err              (err)
  );

  nv_nvdla_pdp_rdma_rd_sched #(.CREDITS(4)) u_dut4 (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .cmd_valid        (b_cmd_valid),
    .cmd_ready        (b_cmd_ready),
    .cmd_addr         (b_cmd_addr),
    .cmd_len          (b_cmd_len),
    .dma_rd_req_valid (b_req_valid),
    .dma_rd_req_ready (b_req_ready),
    .dma_rd_req_addr  (b_req_addr),
    .dma_rd_req_size  (b_req_size),
    .rsp_valid        (b_rsp_valid),
    .rsp_ready        (b_rsp_ready),
    .rsp_mask         (b_rsp_mask),
    .fifo_pop_atoms   (b_pop),
    .credits_avail    (b_credits),
    .done             (b_done),
    .err              (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_addr = '0; cmd_len = '0; req_ready = 0;
    rsp_valid = 0; rsp_ready = 0; rsp_mask = 2'b00; pop = 2'd0;
    b_cmd_valid = 0; b_cmd_addr = '0; b_cmd_len = '0; b_req_ready = 0;
    b_rsp_valid = 0; b_rsp_ready = 0; b_rsp_mask = 2'b00; b_pop = 2'd0;
    tick();
    tick();

    // Reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_req_valid", 64'(req_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_credits", 64'(credits), 64'd64);
    chk("rst_credits4", 64'(b_credits), 64'd4);
    rst = 1'b0;

    // 10 atoms at 0x1000 (low address bits must be ignored)
    req_ready = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 64'h1013; cmd_len = 13'd9;
    tick();
    cmd_valid = 1'b0;
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    chk("t1_r0_valid", 64'(req_valid), 64'd1);
    chk("t1_r0_addr", req_addr, 64'h1000);
    chk("t1_r0_size", 64'(req_size), 64'd3);
    chk("t1_cred0", 64'(credits), 64'd64);
    tick();
    chk("t1_r1_addr", req_addr, 64'h1080);
    chk("t1_r1_size", 64'(req_size), 64'd3);
    chk("t1_cred1", 64'(credits), 64'd60);
    tick();
    chk("t1_r2_addr", req_addr, 64'h1100);
    chk("t1_r2_size", 64'(req_size), 64'd1);
    chk("t1_cred2", 64'(credits), 64'd56);
    tick();
    chk("t1_wait_valid", 64'(req_valid), 64'd0);
    chk("t1_cred3", 64'(credits), 64'd54);

    // Five full beats return the ten atoms; done follows the fifth beat
    rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_mask = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_done", 64'(done), (i == 4) ? 64'd1 : 64'd0);
    end
    rsp_valid = 1'b0;
    chk("t2_ready_in_done", 64'(cmd_ready), 64'd0);
    tick();
    chk("t2_done_once", 64'(done), 64'd0);
    chk("t2_idle_ready", 64'(cmd_ready), 64'd1);
    chk("t2_err", 64'(err), 64'd0);

    // Stalled request holds addr/size and takes no credit
    req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 64'h2000; cmd_len = 13'd5;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 64'(req_valid), 64'd1);
      chk("t4_hold_addr", req_addr, 64'h2000);
      chk("t4_hold_size", 64'(req_size), 64'd3);
      chk("t4_hold_cred", 64'(credits), 64'd54);
      tick();
    end
    req_ready = 1'b1;
    tick();
    chk("t4_r1_addr", req_addr, 64'h2080);
    chk("t4_r1_size", 64'(req_size), 64'd1);
    chk("t4_cred1", 64'(credits), 64'd50);
    tick();
    chk("t4_wait_valid", 64'(req_valid), 64'd0);
    chk("t4_cred2", 64'(credits), 64'd48);
    // 6 atoms back as 1+1+2+2
    rsp_valid = 1'b1; rsp_mask = 2'b01;
    tick();
    rsp_mask = 2'b10;
    tick();
    rsp_mask = 2'b11;
    tick();
    chk("t4_not_done", 64'(done), 64'd0);
    tick();
    rsp_valid = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    tick();
    chk("t4_idle", 64'(cmd_ready), 64'd1);

    // One atom: last request and last response land together, ISSUE goes straight to DONE
    cmd_valid = 1'b1; cmd_addr = 64'h3000; cmd_len = 13'd0;
    tick();
    cmd_valid = 1'b0;
    chk("t7_size", 64'(req_size), 64'd0);
    rsp_valid = 1'b1; rsp_mask = 2'b01;
    tick();
    rsp_valid = 1'b0;
    chk("t7_done", 64'(done), 64'd1);
    chk("t7_err", 64'(err), 64'd0);
    tick();
    chk("t7_idle", 64'(cmd_ready), 64'd1);

    // Four credits: second burst waits for two pops of 2
    b_req_ready = 1'b1;
    b_cmd_valid = 1'b1; b_cmd_addr = 64'h40; b_cmd_len = 13'd7;
    tick();
    b_cmd_valid = 1'b0;
    chk("t3_r0_valid", 64'(b_req_valid), 64'd1);
    chk("t3_r0_size", 64'(b_req_size), 64'd3);
    tick();
    chk("t3_empty_cred", 64'(b_credits), 64'd0);
    chk("t3_blocked", 64'(b_req_valid), 64'd0);
    tick();
    chk("t3_still_blocked", 64'(b_req_valid), 64'd0);
    b_pop = 2'd2;
    tick();
    chk("t3_cred_2", 64'(b_credits), 64'd2);
    chk("t3_blocked_2", 64'(b_req_valid), 64'd0);
    tick();
    b_pop = 2'd0;
    chk("t3_cred_4", 64'(b_credits), 64'd4);
    chk("t3_r1_valid", 64'(b_req_valid), 64'd1);
    chk("t3_r1_addr", b_req_addr, 64'hC0);
    chk("t3_r1_size", 64'(b_req_size), 64'd3);
    tick();
    chk("t3_wait_valid", 64'(b_req_valid), 64'd0);
    chk("t3_cred_after", 64'(b_credits), 64'd0);
    b_pop = 2'd2;
    tick();
    tick();
    b_pop = 2'd0;
    chk("t3_cred_back", 64'(b_credits), 64'd4);
    chk("t3_err", 64'(b_err), 64'd0);

    // Error: response beat in IDLE (rsp_ready low is not a beat)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_ready = 1'b0; rsp_mask = 2'b01;
    tick();
    chk("t5_no_beat", 64'(err), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("t5_idle_beat", 64'(err), 64'd1);
    tick();
    tick();
    tick();
    chk("t5_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_clear", 64'(err), 64'd0);

    // Error: zero mask beat mid-command
    req_ready = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 64'h4000; cmd_len = 13'd7;
    tick();
    cmd_valid = 1'b0;
    rsp_valid = 1'b1; rsp_mask = 2'b00;
    tick();
    rsp_valid = 1'b0;
    chk("t5_zero_mask", 64'(err), 64'd1);
    chk("t6_pre_valid", 64'(req_valid), 64'd1);

    // Reset in ISSUE with requests pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_idle", 64'(cmd_ready), 64'd1);
    chk("t6_valid", 64'(req_valid), 64'd0);
    chk("t6_credits", 64'(credits), 64'd64);
    chk("t6_err", 64'(err), 64'd0);

    // Error: credit return beyond CREDITS saturates
    pop = 2'd1;
    tick();
    pop = 2'd0;
    chk("t5_ovf_err", 64'(err), 64'd1);
    chk("t5_ovf_sat", 64'(credits), 64'd64);
    tick();
    chk("t5_ovf_sticky", 64'(err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
